vga_timing: RTL and testbench

- Generates the raster scan for the VGA path: pixel coordinates (sx, sy), display enable (de), and horizontal/vertical sync.
- Sits directly upstream of the pattern/colour drawing stage. That stage consumes sx, sy and de on the same clock.
- One pixel per clock: clk is the pixel clock (25.175/25 MHz for the 640x480@60 default).
- Also provides line/frame strobes and a free-running frame counter for animated patterns.

---
 rtl/vga_timing.sv | 132 +++++++++++++
 tb/tb_vga_timing.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: raster-scan generator for the VGA path, one pixel per clock.
//
// Ports:
//   clk          pixel clock; all logic on the rising edge
//   rst          synchronous reset, active-high
//   sx, sy       current column / line (0..H_TOTAL-1, 0..V_TOTAL-1)
//   de           display enable: high inside the visible H_RES x V_RES area
//   hsync/vsync  sync outputs, active level set by H_POL / V_POL
//   line_start   one-clock pulse at sx==0
//   frame_start  one-clock pulse at (0,0)
//   frame_count  frames completed since reset, mod 256
//
// Every output is a flop computed from the same next position, so all
// outputs describe the (sx, sy) presented in the same cycle.
module vga_timing #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing: V_TOTAL exceeds 1024");
  end

  // Inclusive bounds keep every comparison at 10 bits even when a total is 1024.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LAST   = 10'(H_RES - 1);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_RES - 1);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_RES + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_RES + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_RES + V_FP + V_SYNC - 1);

  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  // Low for the reset cycles; the first edge after release presents (0,0)
  // instead of advancing, and that first frame_start does not count a frame.
  logic       run_q, run_d;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sx_d          = sx_q;
    sy_d          = sy_q;
    run_d         = 1'b1;

    if (!run_q) begin
      sx_d = '0;
      sy_d = '0;
    end else if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
    end else begin
      sx_d = sx_q + 10'd1;
    end

    // Decode from the next position so the decoded flags land with it.
    de_d          = (sx_d <= H_ACT_LAST) && (sy_d <= V_ACT_LAST);
    hsync_d       = ((sx_d >= H_SYNC_FIRST) && (sx_d <= H_SYNC_LAST)) ? H_POL : ~H_POL;
    vsync_d       = ((sy_d >= V_SYNC_FIRST) && (sy_d <= V_SYNC_LAST)) ? V_POL : ~V_POL;
    line_start_d  = (sx_d == '0);
    frame_start_d = (sx_d == '0) && (sy_d == '0);
    frame_count_d = frame_count_q + {7'd0, frame_start_d & run_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q          <= '0;
      sy_q          <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      run_q         <= 1'b0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      run_q         <= run_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing. Three instances run side by side from one clock:
//   unit 0: default 640x480 timing (horizontal edges, mid-frame reset)
//   unit 1: reduced 16x12 timing (vertical edges, full-frame totals)
//   unit 2: tiny 4x3 timing, active-high syncs (sync positions, frame_count wrap)
// Expected outputs are queued with the cycle they are due; a monitor on the
// falling edge pops and compares whatever is due that cycle.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   cyc;
    int   unit;
    obs_t v;
  } exp_t;

  typedef struct {
    int de_cnt;
    int hs_cnt;
    int vs_cnt;
    int clk_cnt;
  } stat_t;

  localparam int END_CYC = 36200;

  logic clk = 1'b0;
  logic rst_d, rst_o;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t  exp_q[$];
  stat_t stat_q[$];

  logic [9:0] d_sx, d_sy, m_sx, m_sy, s_sx, s_sy;
  logic       d_de, d_hs, d_vs, d_ls, d_fs;
  logic       m_de, m_hs, m_vs, m_ls, m_fs;
  logic       s_de, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] d_fc, m_fc, s_fc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing dut_d (
    .clk(clk), .rst(rst_d), .sx(d_sx), .sy(d_sy), .de(d_de), .hsync(d_hs),
    .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut_m (
    .clk(clk), .rst(rst_o), .sx(m_sx), .sy(m_sy), .de(m_de), .hsync(m_hs),
    .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs), .frame_count(m_fc)
  );

  vga_timing #(
    .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_o), .sx(s_sx), .sy(s_sy), .de(s_de), .hsync(s_hs),
    .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  function automatic obs_t observe(input int u);
    case (u)
      0:       observe = {d_sx, d_sy, d_de, d_hs, d_vs, d_ls, d_fs, d_fc};
      1:       observe = {m_sx, m_sy, m_de, m_hs, m_vs, m_ls, m_fs, m_fc};
      default: observe = {s_sx, s_sy, s_de, s_hs, s_vs, s_ls, s_fs, s_fc};
    endcase
  endfunction

  // l is the scan index counted from the first post-reset cycle (l=0 -> (0,0));
  // l=-1 is the last reset cycle.
  task automatic exp_at(input int l, input int u, input int x, input int y,
                        input bit de, input bit hs, input bit vs,
                        input bit ls, input bit fs, input int fc);
    exp_t e;
    e.cyc  = l + 4;
    e.unit = u;
    e.v    = {10'(x), 10'(y), de, hs, vs, ls, fs, 8'(fc)};
    exp_q.push_back(e);
  endtask

  task automatic report(input string name, input obs_t got, input obs_t want);
    $display("FAIL %s cyc %0d: got sx=%0d sy=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected sx=%0d sy=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
             name, cyc, got.sx, got.sy, got.de, got.hs, got.vs, got.ls, got.fs, got.fc,
             want.sx, want.sy, want.de, want.hs, want.vs, want.ls, want.fs, want.fc);
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        obs_t got;
        got = observe(exp_q[i].unit);
        checks++;
        if (got !== exp_q[i].v) begin
          errors++;
          report($sformatf("unit%0d", exp_q[i].unit), got, exp_q[i].v);
        end
        exp_q.delete(i);
      end
    end
  end

  // Frame totals for unit 1, closed out at each frame_start.
  int m_frames = 0;
  int m_de_cnt, m_hs_cnt, m_vs_cnt, m_clk_cnt;
  always @(negedge clk) begin
    if (m_fs === 1'b1) begin
      if (m_frames > 0 && stat_q.size() > 0) begin
        stat_t s;
        s = stat_q.pop_front();
        checks++;
        if (m_de_cnt != s.de_cnt || m_hs_cnt != s.hs_cnt ||
            m_vs_cnt != s.vs_cnt || m_clk_cnt != s.clk_cnt) begin
          errors++;
          $display("FAIL frame_totals frame %0d: got de=%0d hs=%0d vs=%0d clk=%0d, expected de=%0d hs=%0d vs=%0d clk=%0d",
                   m_frames - 1, m_de_cnt, m_hs_cnt, m_vs_cnt, m_clk_cnt,
                   s.de_cnt, s.hs_cnt, s.vs_cnt, s.clk_cnt);
        end
      end
      m_frames++;
      m_de_cnt = 0; m_hs_cnt = 0; m_vs_cnt = 0; m_clk_cnt = 0;
    end
    if (m_frames > 0) begin
      m_clk_cnt++;
      if (m_de === 1'b1) m_de_cnt++;
      if (m_hs === 1'b0) m_hs_cnt++;
      if (m_vs === 1'b0) m_vs_cnt++;
    end
  end

  initial begin
    stat_t st;
    rst_d = 1'b1;
    rst_o = 1'b1;

    // Reset values and the first post-reset cycle, all units.
    exp_at(-1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    exp_at(-1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    exp_at(-1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_at( 0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
    exp_at( 0, 1, 0, 0, 1, 1, 1, 1, 1, 0);
    exp_at( 0, 2, 0, 0, 1, 0, 0, 1, 1, 0);

    // Unit 0: line 0 horizontal edges and wrap into line 1.
    exp_at(639, 0, 639, 0, 1, 1, 1, 0, 0, 0);
    exp_at(640, 0, 640, 0, 0, 1, 1, 0, 0, 0);
    exp_at(655, 0, 655, 0, 0, 1, 1, 0, 0, 0);
    exp_at(656, 0, 656, 0, 0, 0, 1, 0, 0, 0);
    exp_at(751, 0, 751, 0, 0, 0, 1, 0, 0, 0);
    exp_at(752, 0, 752, 0, 0, 1, 1, 0, 0, 0);
    exp_at(799, 0, 799, 0, 0, 1, 1, 0, 0, 0);
    exp_at(800, 0,   0, 1, 1, 1, 1, 1, 0, 0);

    // Unit 0: one-cycle reset at (123,45), l = 45*800+123.
    exp_at(36123, 0, 123, 45, 1, 1, 1, 0, 0, 0);
    exp_at(36124, 0,   0,  0, 0, 1, 1, 0, 0, 0);
    exp_at(36125, 0,   0,  0, 1, 1, 1, 1, 1, 0);
    exp_at(36126, 0,   1,  0, 1, 1, 1, 0, 0, 0);

    // Unit 1 (24 x 20 total): horizontal blanking/sync, vertical blanking/sync, frame wrap.
    exp_at( 16, 1, 16,  0, 0, 1, 1, 0, 0, 0);
    exp_at( 18, 1, 18,  0, 0, 0, 1, 0, 0, 0);
    exp_at( 21, 1, 21,  0, 0, 1, 1, 0, 0, 0);
    exp_at(288, 1,  0, 12, 0, 1, 1, 1, 0, 0);
    exp_at(335, 1, 23, 13, 0, 1, 1, 0, 0, 0);
    exp_at(336, 1,  0, 14, 0, 1, 0, 1, 0, 0);
    exp_at(383, 1, 23, 15, 0, 1, 0, 0, 0, 0);
    exp_at(384, 1,  0, 16, 0, 1, 1, 1, 0, 0);
    exp_at(479, 1, 23, 19, 0, 1, 1, 0, 0, 0);
    exp_at(480, 1,  0,  0, 1, 1, 1, 1, 1, 1);
    exp_at(960, 1,  0,  0, 1, 1, 1, 1, 1, 2);
    // Two frames with identical totals: de 16*12, hsync 3*20, vsync 2*24, 24*20 clocks.
    st = '{de_cnt: 192, hs_cnt: 60, vs_cnt: 48, clk_cnt: 480};
    stat_q.push_back(st);
    stat_q.push_back(st);

    // Unit 2 (7 x 6 total, active-high syncs): sync only at sx=5 / sy=4, count wrap.
    exp_at(    4, 2, 4, 0, 0, 0, 0, 0, 0,   0);
    exp_at(    5, 2, 5, 0, 0, 1, 0, 0, 0,   0);
    exp_at(    6, 2, 6, 0, 0, 0, 0, 0, 0,   0);
    exp_at(    7, 2, 0, 1, 1, 0, 0, 1, 0,   0);
    exp_at(   27, 2, 6, 3, 0, 0, 0, 0, 0,   0);
    exp_at(   28, 2, 0, 4, 0, 0, 1, 1, 0,   0);
    exp_at(   33, 2, 5, 4, 0, 1, 1, 0, 0,   0);
    exp_at(   34, 2, 6, 4, 0, 0, 1, 0, 0,   0);
    exp_at(   35, 2, 0, 5, 0, 0, 0, 1, 0,   0);
    exp_at(   42, 2, 0, 0, 1, 0, 0, 1, 1,   1);
    exp_at(10710, 2, 0, 0, 1, 0, 0, 1, 1, 255);
    exp_at(10752, 2, 0, 0, 1, 0, 0, 1, 1,   0);
    exp_at(10753, 2, 1, 0, 1, 0, 0, 0, 0,   0);

    // Hold reset for three edges, release before the fourth.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    rst_o = 1'b0;

    // Mid-frame reset on unit 0: the edge after (123,45) is shown sees rst high.
    while (cyc < 36127) @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;

    while (cyc < END_CYC) @(negedge clk);
    @(posedge clk);

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL unit%0d expectation for cycle %0d never compared", exp_q[i].unit, exp_q[i].cyc);
    end
    foreach (stat_q[i]) begin
      checks++;
      errors++;
      $display("FAIL frame_totals: expected frame boundary not seen (got %0d frame starts)", m_frames);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
